// File: rtl/punc_control_pkg.sv
// Shared PUnC definitions: FSM states, LC3 opcodes, ALU codes and datapath select encodings.
// Imported by both the control unit and the datapath.
package punc_defs;

  typedef enum logic [2:0] {
    StInit   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StExec2  = 3'd4,
    StHalt   = 3'd5
  } state_e;

  localparam logic [3:0] OpBr   = 4'b0000;
  localparam logic [3:0] OpAdd  = 4'b0001;
  localparam logic [3:0] OpLd   = 4'b0010;
  localparam logic [3:0] OpSt   = 4'b0011;
  localparam logic [3:0] OpJsr  = 4'b0100;
  localparam logic [3:0] OpAnd  = 4'b0101;
  localparam logic [3:0] OpLdr  = 4'b0110;
  localparam logic [3:0] OpStr  = 4'b0111;
  localparam logic [3:0] OpRsv0 = 4'b1000;
  localparam logic [3:0] OpNot  = 4'b1001;
  localparam logic [3:0] OpLdi  = 4'b1010;
  localparam logic [3:0] OpSti  = 4'b1011;
  localparam logic [3:0] OpJmp  = 4'b1100;
  localparam logic [3:0] OpRsv1 = 4'b1101;
  localparam logic [3:0] OpLea  = 4'b1110;
  localparam logic [3:0] OpHalt = 4'b1111;

  localparam logic [2:0] AluAdd  = 3'd0;
  localparam logic [2:0] AluAddI = 3'd1;
  localparam logic [2:0] AluNot  = 3'd2;
  localparam logic [2:0] AluAnd  = 3'd3;
  localparam logic [2:0] AluAndI = 3'd4;
  localparam logic [2:0] AluPass = 3'd5;

  localparam logic [1:0] MemRAddrPc        = 2'd0;
  localparam logic [1:0] MemRAddrPcSext9   = 2'd1;
  localparam logic [1:0] MemRAddrBaseSext6 = 2'd2;
  localparam logic [1:0] MemRAddrLdiReg    = 2'd3;

  localparam logic [1:0] MemWAddrPcSext9   = 2'd0;
  localparam logic [1:0] MemWAddrBaseSext6 = 2'd1;
  localparam logic [1:0] MemWAddrMemData   = 2'd2;

  localparam logic       MemWDataRf = 1'b0;

  // r0 defaults to ir[8:6] (SR1 / BASE); r1 defaults to ir[2:0] (SR2)
  localparam logic       RfR0Sr1  = 1'b0;
  localparam logic       RfR0Sr   = 1'b1;
  localparam logic       RfR1Sr2  = 1'b0;
  localparam logic       RfR1Base = 1'b1;

  localparam logic [1:0] RfWDataAlu     = 2'd0;
  localparam logic [1:0] RfWDataMem     = 2'd1;
  localparam logic [1:0] RfWDataPcSext9 = 2'd2;
  localparam logic [1:0] RfWDataPc      = 2'd3;

  localparam logic       RfWAddrDr = 1'b0;
  localparam logic       RfWAddrR7 = 1'b1;

  localparam logic [1:0] PcLdPcSext9  = 2'd0;
  localparam logic [1:0] PcLdPcSext11 = 2'd1;
  localparam logic [1:0] PcLdBase     = 2'd2;

  localparam logic       CondLdRf  = 1'b0;
  localparam logic       CondLdMem = 1'b1;

  function automatic logic op_is_reserved(input logic [3:0] op);
    return (op == OpRsv0) || (op == OpRsv1);
  endfunction

endpackage

// File: rtl/punc_control_if.sv
// Control <-> datapath bundle: instruction/flags up from the datapath, strobes and selects down.
interface punc_control_if;
  logic [15:0] ir;
  logic        n;
  logic        z;
  logic        p;

  logic        mem_w_en;
  logic [1:0]  mem_w_addr_sel;
  logic        mem_w_data_sel;
  logic [1:0]  mem_r_addr_sel;
  logic        rf_w_en;
  logic        rf_r0_addr_sel;
  logic        rf_r1_addr_sel;
  logic [1:0]  rf_w_data_sel;
  logic        rf_w_addr_sel;
  logic        ir_ld;
  logic        pc_ld;
  logic        pc_clr;
  logic        pc_inc;
  logic [1:0]  pc_ld_data_sel;
  logic [2:0]  alu_sel;
  logic        cond_ld;
  logic        cond_ld_data_sel;
  logic        ldi_reg_ld;
  logic        halted;

  modport master (
    input  ir, n, z, p,
    output mem_w_en, mem_w_addr_sel, mem_w_data_sel, mem_r_addr_sel,
           rf_w_en, rf_r0_addr_sel, rf_r1_addr_sel, rf_w_data_sel, rf_w_addr_sel,
           ir_ld, pc_ld, pc_clr, pc_inc, pc_ld_data_sel,
           alu_sel, cond_ld, cond_ld_data_sel, ldi_reg_ld, halted
  );

  modport slave (
    output ir, n, z, p,
    input  mem_w_en, mem_w_addr_sel, mem_w_data_sel, mem_r_addr_sel,
           rf_w_en, rf_r0_addr_sel, rf_r1_addr_sel, rf_w_data_sel, rf_w_addr_sel,
           ir_ld, pc_ld, pc_clr, pc_inc, pc_ld_data_sel,
           alu_sel, cond_ld, cond_ld_data_sel, ldi_reg_ld, halted
  );
endinterface

// File: rtl/punc_branch_eval.sv
// Branch condition: taken when any requested flag in ir[11:9] (n,z,p) is set.
module punc_branch_eval (
    input  logic [2:0] nzp_mask,
    input  logic       n,
    input  logic       z,
    input  logic       p,
    output logic       taken
);

    assign taken = |(nzp_mask & {n, z, p});

endmodule

// File: rtl/punc_control.sv
// PUnC LC3 multi-cycle control FSM: fetch, decode, execute; Moore outputs from state and opcode.
module punc_control
    import punc_defs::*;
(
    input  logic                  clk,
    input  logic                  rst,
    punc_control_if.master        bus
);

    state_e     state_q, state_d;
    logic [3:0] opcode;
    logic       br_taken;
    logic       wr_dr;

    assign opcode = bus.ir[15:12];

    // Control never looks at the register/offset fields
    logic unused_ir;
    assign unused_ir = ^{bus.ir[8:6], bus.ir[4:0]};

    punc_branch_eval u_branch_eval (
        .nzp_mask (bus.ir[11:9]),
        .n        (bus.n),
        .z        (bus.z),
        .p        (bus.p),
        .taken    (br_taken)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        wr_dr                = 1'b0;
        bus.mem_w_en         = 1'b0;
        bus.mem_w_addr_sel   = MemWAddrPcSext9;
        bus.mem_w_data_sel   = MemWDataRf;
        bus.mem_r_addr_sel   = MemRAddrPc;
        bus.rf_w_en          = 1'b0;
        bus.rf_r0_addr_sel   = RfR0Sr1;
        bus.rf_r1_addr_sel   = RfR1Sr2;
        bus.rf_w_data_sel    = RfWDataAlu;
        bus.rf_w_addr_sel    = RfWAddrDr;
        bus.ir_ld            = 1'b0;
        bus.pc_ld            = 1'b0;
        bus.pc_clr           = 1'b0;
        bus.pc_inc           = 1'b0;
        bus.pc_ld_data_sel   = PcLdPcSext9;
        bus.alu_sel          = AluAdd;
        bus.cond_ld          = 1'b0;
        bus.cond_ld_data_sel = CondLdRf;
        bus.ldi_reg_ld       = 1'b0;
        bus.halted           = 1'b0;

        case (state_q)
            StInit: begin
                bus.pc_clr = 1'b1;
                state_d    = StFetch;
            end

            StFetch: begin
                bus.mem_r_addr_sel = MemRAddrPc;
                bus.ir_ld          = 1'b1;
                bus.pc_inc         = 1'b1;
                state_d            = StDecode;
            end

            StDecode: begin
                if (opcode == OpHalt) begin
                    state_d = StHalt;
                end else if (op_is_reserved(opcode)) begin
                    state_d = StFetch;
                end else begin
                    state_d = StExec;
                end
            end

            StExec: begin
                state_d = StFetch;
                case (opcode)
                    OpAdd, OpAnd: begin
                        wr_dr             = 1'b1;
                        bus.rf_w_data_sel = RfWDataAlu;
                        if (bus.ir[5]) begin
                            bus.alu_sel = (opcode == OpAdd) ? AluAddI : AluAndI;
                        end else begin
                            bus.alu_sel        = (opcode == OpAdd) ? AluAdd : AluAnd;
                            bus.rf_r1_addr_sel = RfR1Sr2;
                        end
                    end
                    OpNot: begin
                        wr_dr             = 1'b1;
                        bus.rf_w_data_sel = RfWDataAlu;
                        bus.alu_sel       = AluNot;
                    end
                    OpLd: begin
                        wr_dr              = 1'b1;
                        bus.mem_r_addr_sel = MemRAddrPcSext9;
                        bus.rf_w_data_sel  = RfWDataMem;
                    end
                    OpLdr: begin
                        wr_dr              = 1'b1;
                        bus.mem_r_addr_sel = MemRAddrBaseSext6;
                        bus.rf_w_data_sel  = RfWDataMem;
                    end
                    OpLea: begin
                        wr_dr             = 1'b1;
                        bus.rf_w_data_sel = RfWDataPcSext9;
                    end
                    OpSt: begin
                        bus.mem_w_en       = 1'b1;
                        bus.mem_w_addr_sel = MemWAddrPcSext9;
                        bus.mem_w_data_sel = MemWDataRf;
                        bus.rf_r0_addr_sel = RfR0Sr;
                    end
                    OpStr: begin
                        bus.mem_w_en       = 1'b1;
                        bus.mem_w_addr_sel = MemWAddrBaseSext6;
                        bus.mem_w_data_sel = MemWDataRf;
                        bus.rf_r0_addr_sel = RfR0Sr;
                        bus.rf_r1_addr_sel = RfR1Base;
                    end
                    OpBr: begin
                        bus.pc_ld          = br_taken;
                        bus.pc_ld_data_sel = PcLdPcSext9;
                    end
                    OpJmp: begin
                        bus.pc_ld          = 1'b1;
                        bus.pc_ld_data_sel = PcLdBase;
                    end
                    OpJsr: begin
                        // PC was already incremented in FETCH, so R7 gets the return address
                        bus.rf_w_en        = 1'b1;
                        bus.rf_w_addr_sel  = RfWAddrR7;
                        bus.rf_w_data_sel  = RfWDataPc;
                        bus.pc_ld          = 1'b1;
                        bus.pc_ld_data_sel = bus.ir[11] ? PcLdPcSext11 : PcLdBase;
                    end
                    OpLdi, OpSti: begin
                        bus.mem_r_addr_sel = MemRAddrPcSext9;
                        bus.ldi_reg_ld     = 1'b1;
                        state_d            = StExec2;
                    end
                    default: ;
                endcase
            end

            StExec2: begin
                state_d            = StFetch;
                bus.mem_r_addr_sel = MemRAddrLdiReg;
                if (opcode == OpLdi) begin
                    wr_dr             = 1'b1;
                    bus.rf_w_data_sel = RfWDataMem;
                end else if (opcode == OpSti) begin
                    bus.mem_w_en       = 1'b1;
                    bus.mem_w_addr_sel = MemWAddrMemData;
                    bus.mem_w_data_sel = MemWDataRf;
                    bus.rf_r0_addr_sel = RfR0Sr;
                end
            end

            StHalt: begin
                bus.halted = 1'b1;
                state_d    = StHalt;
            end

            default: state_d = StInit;
        endcase

        if (wr_dr) begin
            bus.rf_w_en          = 1'b1;
            bus.rf_w_addr_sel    = RfWAddrDr;
            bus.cond_ld          = 1'b1;
            bus.cond_ld_data_sel = CondLdRf;
        end
    end

endmodule

// File: tb/tb_punc_control.sv
// Bench for punc_control: per-instruction cycle model checked against the DUT every cycle.
module tb_punc_control;

    typedef struct packed {
        logic       mem_w_en;
        logic [1:0] mem_w_addr_sel;
        logic       mem_w_data_sel;
        logic [1:0] mem_r_addr_sel;
        logic       rf_w_en;
        logic       rf_r0_addr_sel;
        logic       rf_r1_addr_sel;
        logic [1:0] rf_w_data_sel;
        logic       rf_w_addr_sel;
        logic       ir_ld;
        logic       pc_ld;
        logic       pc_clr;
        logic       pc_inc;
        logic [1:0] pc_ld_data_sel;
        logic [2:0] alu_sel;
        logic       cond_ld;
        logic       cond_ld_data_sel;
        logic       ldi_reg_ld;
        logic       halted;
    } ctl_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    punc_control_if bus ();

    punc_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    ctl_t  exp_q[$];
    string tag_q[$];
    int    pass_cnt  = 0;
    int    total_cnt = 0;

    function automatic ctl_t actual();
        ctl_t a;
        a.mem_w_en         = bus.mem_w_en;
        a.mem_w_addr_sel   = bus.mem_w_addr_sel;
        a.mem_w_data_sel   = bus.mem_w_data_sel;
        a.mem_r_addr_sel   = bus.mem_r_addr_sel;
        a.rf_w_en          = bus.rf_w_en;
        a.rf_r0_addr_sel   = bus.rf_r0_addr_sel;
        a.rf_r1_addr_sel   = bus.rf_r1_addr_sel;
        a.rf_w_data_sel    = bus.rf_w_data_sel;
        a.rf_w_addr_sel    = bus.rf_w_addr_sel;
        a.ir_ld            = bus.ir_ld;
        a.pc_ld            = bus.pc_ld;
        a.pc_clr           = bus.pc_clr;
        a.pc_inc           = bus.pc_inc;
        a.pc_ld_data_sel   = bus.pc_ld_data_sel;
        a.alu_sel          = bus.alu_sel;
        a.cond_ld          = bus.cond_ld;
        a.cond_ld_data_sel = bus.cond_ld_data_sel;
        a.ldi_reg_ld       = bus.ldi_reg_ld;
        a.halted           = bus.halted;
        return a;
    endfunction

    // DR write with flags updated from the register-file write data
    function automatic ctl_t write_dr(input ctl_t c, input logic [1:0] data_sel);
        ctl_t r = c;
        r.rf_w_en       = 1'b1;
        r.rf_w_data_sel = data_sel;
        r.cond_ld       = 1'b1;
        return r;
    endfunction

    // Expected outputs for cycle `phase` of an instruction (0 fetch, 1 decode, 2.. execute)
    function automatic ctl_t model_cycle(input int phase, input logic [15:0] ir,
                                         input logic n, input logic z, input logic p);
        ctl_t       c  = '0;
        logic [3:0] op = ir[15:12];
        if (phase == 0) begin
            c.ir_ld  = 1'b1;
            c.pc_inc = 1'b1;
        end else if (phase == 2) begin
            case (op)
                4'h1: begin c = write_dr(c, 2'd0); c.alu_sel = ir[5] ? 3'd1 : 3'd0; end
                4'h5: begin c = write_dr(c, 2'd0); c.alu_sel = ir[5] ? 3'd4 : 3'd3; end
                4'h9: begin c = write_dr(c, 2'd0); c.alu_sel = 3'd2; end
                4'h2: begin c = write_dr(c, 2'd1); c.mem_r_addr_sel = 2'd1; end
                4'h6: begin c = write_dr(c, 2'd1); c.mem_r_addr_sel = 2'd2; end
                4'hE: c = write_dr(c, 2'd2);
                4'h3: begin c.mem_w_en = 1'b1; c.rf_r0_addr_sel = 1'b1; end
                4'h7: begin
                    c.mem_w_en = 1'b1; c.mem_w_addr_sel = 2'd1;
                    c.rf_r0_addr_sel = 1'b1; c.rf_r1_addr_sel = 1'b1;
                end
                4'h0: c.pc_ld = (ir[11] && n) || (ir[10] && z) || (ir[9] && p);
                4'hC: begin c.pc_ld = 1'b1; c.pc_ld_data_sel = 2'd2; end
                4'h4: begin
                    c.rf_w_en = 1'b1; c.rf_w_addr_sel = 1'b1; c.rf_w_data_sel = 2'd3;
                    c.pc_ld = 1'b1; c.pc_ld_data_sel = ir[11] ? 2'd1 : 2'd2;
                end
                4'hA, 4'hB: begin c.mem_r_addr_sel = 2'd1; c.ldi_reg_ld = 1'b1; end
                default: ;
            endcase
        end else if (phase == 3) begin
            c.mem_r_addr_sel = 2'd3;
            if (op == 4'hA) begin
                c = write_dr(c, 2'd1);
            end else begin
                c.mem_w_en = 1'b1; c.mem_w_addr_sel = 2'd2; c.rf_r0_addr_sel = 1'b1;
            end
        end
        return c;
    endfunction

    function automatic int model_len(input logic [15:0] ir);
        case (ir[15:12])
            4'h8, 4'hD: return 2;
            4'hA, 4'hB: return 4;
            default:    return 3;
        endcase
    endfunction

    task automatic pin(input ctl_t got, input ctl_t want, input string name);
        total_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: model gives %h, hand value %h", name, got, want);
    endtask

    task automatic step(input ctl_t e, input string t);
        exp_q.push_back(e);
        tag_q.push_back(t);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [15:0] ir, input logic n, input logic z, input logic p);
        bus.ir = ir;
        bus.n  = n;
        bus.z  = z;
        bus.p  = p;
        for (int ph = 0; ph < model_len(ir); ph++)
            step(model_cycle(ph, ir, n, z, p), $sformatf("ir=%h ph%0d", ir, ph));
    endtask

    ctl_t rst_e, halt_e;

    // Asynchronous reset mid-cycle, then release back through INIT
    task automatic reset_now();
        #1 rst = 1'b1;
        step(rst_e, "async rst");
        step(rst_e, "rst held");
        rst = 1'b0;
        step(rst_e, "init");
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            ctl_t  e, a;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = actual();
            total_cnt++;
            if (a === e) pass_cnt++;
            else $display("FAIL %s: dut %h expected %h", t, a, e);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        ctl_t h;
        rst_e        = '0;
        rst_e.pc_clr = 1'b1;
        halt_e        = '0;
        halt_e.halted = 1'b1;
        bus.ir = 16'h0000;
        bus.n  = 1'b0;
        bus.z  = 1'b0;
        bus.p  = 1'b0;

        // Hand-derived values that pin the model
        h = '0; h.rf_w_en = 1'b1; h.cond_ld = 1'b1; h.alu_sel = 3'd1;
        pin(model_cycle(2, 16'h1261, 1'b0, 1'b0, 1'b0), h, "pin add_i");
        h = '0; h.pc_ld = 1'b1;
        pin(model_cycle(2, 16'h0403, 1'b0, 1'b1, 1'b0), h, "pin brz taken");
        h = '0;
        pin(model_cycle(2, 16'h0403, 1'b1, 1'b0, 1'b0), h, "pin brz not taken");
        h = '0; h.rf_w_en = 1'b1; h.rf_w_addr_sel = 1'b1; h.rf_w_data_sel = 2'd3;
        h.pc_ld = 1'b1; h.pc_ld_data_sel = 2'd1;
        pin(model_cycle(2, 16'h4802, 1'b0, 1'b0, 1'b0), h, "pin jsr");
        h.pc_ld_data_sel = 2'd2;
        pin(model_cycle(2, 16'h4080, 1'b0, 1'b0, 1'b0), h, "pin jsrr");
        h = '0; h.mem_r_addr_sel = 2'd3; h.rf_w_en = 1'b1; h.rf_w_data_sel = 2'd1;
        h.cond_ld = 1'b1;
        pin(model_cycle(3, 16'hA405, 1'b0, 1'b0, 1'b0), h, "pin ldi exec2");

        @(posedge clk);
        #1;
        repeat (3) step(rst_e, "reset hold");
        rst = 1'b0;
        step(rst_e, "init");

        run_instr(16'h1261, 1'b0, 1'b0, 1'b0);   // ADD R1,R1,#1
        run_instr(16'h5042, 1'b0, 1'b0, 1'b0);   // AND R0,R1,R2
        run_instr(16'h967F, 1'b0, 1'b0, 1'b0);   // NOT
        run_instr(16'h2205, 1'b0, 1'b0, 1'b0);   // LD
        run_instr(16'h6441, 1'b0, 1'b0, 1'b0);   // LDR
        run_instr(16'hE3FF, 1'b0, 1'b0, 1'b0);   // LEA
        run_instr(16'h3605, 1'b0, 1'b0, 1'b0);   // ST
        run_instr(16'h7842, 1'b0, 1'b0, 1'b0);   // STR
        run_instr(16'h0403, 1'b0, 1'b1, 1'b0);   // BRz taken
        run_instr(16'h0403, 1'b1, 1'b0, 1'b0);   // BRz not taken
        run_instr(16'h0E01, 1'b0, 1'b0, 1'b1);   // BRnzp on p
        run_instr(16'h0001, 1'b1, 1'b1, 1'b1);   // BR with empty mask
        run_instr(16'hC080, 1'b0, 1'b0, 1'b0);   // JMP R2
        run_instr(16'h4802, 1'b0, 1'b0, 1'b0);   // JSR
        run_instr(16'h4080, 1'b0, 1'b0, 1'b0);   // JSRR R2
        run_instr(16'hA405, 1'b0, 1'b0, 1'b0);   // LDI
        run_instr(16'hB605, 1'b0, 1'b0, 1'b0);   // STI
        run_instr(16'h8000, 1'b0, 1'b0, 1'b0);   // reserved
        run_instr(16'hD123, 1'b0, 1'b0, 1'b0);   // reserved
        run_instr(16'h1021, 1'b0, 1'b0, 1'b0);   // ADD after reserved

        // Reset landing in EXEC of an LD
        bus.ir = 16'h2205;
        step(model_cycle(0, 16'h2205, 1'b0, 1'b0, 1'b0), "ld fetch");
        step(model_cycle(1, 16'h2205, 1'b0, 1'b0, 1'b0), "ld decode");
        reset_now();

        bus.ir = 16'hF025;
        step(model_cycle(0, 16'hF025, 1'b0, 1'b0, 1'b0), "halt fetch");
        step(model_cycle(1, 16'hF025, 1'b0, 1'b0, 1'b0), "halt decode");
        bus.ir = 16'h1261;   // ir changes must not wake a halted core
        repeat (12) step(halt_e, "halted");
        reset_now();
        run_instr(16'h1261, 1'b0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        total_cnt++;
        if (exp_q.size() == 0) pass_cnt++;
        else $display("FAIL drain: %0d expectations left, required 0", exp_q.size());

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
